// File: rtl/axi_r_arb_mux.sv
// AXI read-data arbiter/mux: burst-locked round-robin over NUM_S slaves into a 1-entry output register.
// Build option AXI_R_ARB_MUX_DECERR_EN: sink beats with a non-one-hot master select and count them in err_cnt.
//
// state | meaning
// EMPTY | output register holds no beat
// FULL  | output register holds a beat presented on RVALID_M
module axi_r_arb_mux #(
    parameter int NUM_S     = 3,
    parameter int NUM_M     = 2,
    parameter int ID_BITS   = 4,
    parameter int DATA_BITS = 32,
    localparam int IDS_BITS = ID_BITS + NUM_M
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_S*IDS_BITS-1:0]  RID_S,
    input  logic [NUM_S*DATA_BITS-1:0] RDATA_S,
    input  logic [NUM_S*2-1:0]         RRESP_S,
    input  logic [NUM_S-1:0]           RLAST_S,
    input  logic [NUM_S-1:0]           RVALID_S,
    output logic [NUM_S-1:0]           RREADY_S,
    output logic [ID_BITS-1:0]         RID_M,
    output logic [DATA_BITS-1:0]       RDATA_M,
    output logic [1:0]                 RRESP_M,
    output logic                       RLAST_M,
    output logic [NUM_M-1:0]           RVALID_M,
    input  logic [NUM_M-1:0]           RREADY_M
`ifdef AXI_R_ARB_MUX_DECERR_EN
    ,
    output logic [15:0]                err_cnt
`endif
);

    localparam int PTR_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

`ifdef AXI_R_ARB_MUX_DECERR_EN
    localparam bit SINK_EN = 1'b1;
`else
    localparam bit SINK_EN = 1'b0;
`endif

    typedef enum logic {EMPTY, FULL} ent_t;

    logic [IDS_BITS-1:0]  rid_s  [NUM_S];
    logic [DATA_BITS-1:0] data_s [NUM_S];
    logic [1:0]           resp_s [NUM_S];

    for (genvar k = 0; k < NUM_S; k++) begin : g_unpack
        assign rid_s[k]  = RID_S[k*IDS_BITS +: IDS_BITS];
        assign data_s[k] = RDATA_S[k*DATA_BITS +: DATA_BITS];
        assign resp_s[k] = RRESP_S[k*2 +: 2];
    end

    ent_t                 ent_q, ent_d;
    logic                 lock_q, lock_d;
    logic [PTR_W-1:0]     lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_M-1:0]     sel_q, sel_d;
    logic [ID_BITS-1:0]   rid_q, rid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [1:0]           resp_q, resp_d;
    logic                 last_q, last_d;

    logic [PTR_W-1:0]     gnt_idx, cand_idx;
    logic                 gnt_vld;
    int                   cand;
    logic [NUM_M-1:0]     sel_g;
    logic                 sel_ok, drain, space, hs, capture;

    // Grant: the locked slave while mid-burst, otherwise first valid slave after the last RLAST winner.
    always_comb begin
        gnt_idx  = '0;
        gnt_vld  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (lock_q) begin
            gnt_idx = lock_idx_q;
            gnt_vld = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_S; i++) begin
                cand = int'(rr_ptr_q) + i;
                if (cand >= NUM_S) cand = cand - NUM_S;
                cand_idx = PTR_W'(cand);
                if (!gnt_vld && RVALID_S[cand_idx]) begin
                    gnt_idx = cand_idx;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    assign sel_g   = rid_s[gnt_idx][IDS_BITS-1:ID_BITS];
    assign sel_ok  = $onehot(sel_g);
    assign drain   = (ent_q == FULL) && ((sel_q & RREADY_M) != '0);
    assign space   = (ent_q == EMPTY) || drain;
    // Invalid-select beats bypass the register entirely, so sinking them never waits for space.
    assign hs      = !rst && gnt_vld && RVALID_S[gnt_idx] && (sel_ok ? space : SINK_EN);
    assign capture = hs && sel_ok;

    always_comb begin
        ent_d      = ent_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        rid_d      = rid_q;
        data_d     = data_q;
        resp_d     = resp_q;
        last_d     = last_q;
        if (capture) begin
            ent_d  = FULL;
            sel_d  = sel_g;
            rid_d  = rid_s[gnt_idx][ID_BITS-1:0];
            data_d = data_s[gnt_idx];
            resp_d = resp_s[gnt_idx];
            last_d = RLAST_S[gnt_idx];
        end else if (drain) begin
            ent_d = EMPTY;
        end
        if (hs) begin
            if (RLAST_S[gnt_idx]) begin
                lock_d   = 1'b0;
                rr_ptr_d = gnt_idx;
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = gnt_idx;
            end
        end
    end

    always_comb begin
        RREADY_S = '0;
        for (int k = 0; k < NUM_S; k++) begin
            RREADY_S[k] = hs && (gnt_idx == PTR_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q      <= EMPTY;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_ptr_q   <= PTR_W'(NUM_S - 1);
            sel_q      <= '0;
            rid_q      <= '0;
            data_q     <= '0;
            resp_q     <= 2'b11;
            last_q     <= 1'b0;
        end else begin
            ent_q      <= ent_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            rid_q      <= rid_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            last_q     <= last_d;
        end
    end

    assign RVALID_M = (ent_q == FULL) ? sel_q : '0;
    assign RID_M    = rid_q;
    assign RDATA_M  = data_q;
    assign RRESP_M  = resp_q;
    assign RLAST_M  = last_q;

`ifdef AXI_R_ARB_MUX_DECERR_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (hs && !sel_ok && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi_r_arb_mux.sv
// Self-checking bench for axi_r_arb_mux: slave queues drive stimulus, expected master beats go through a scoreboard.
module tb_axi_r_arb_mux;
    localparam int NUM_S     = 3;
    localparam int NUM_M     = 2;
    localparam int ID_BITS   = 4;
    localparam int DATA_BITS = 32;
    localparam int IDS_BITS  = ID_BITS + NUM_M;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_S*IDS_BITS-1:0]  RID_S;
    logic [NUM_S*DATA_BITS-1:0] RDATA_S;
    logic [NUM_S*2-1:0]         RRESP_S;
    logic [NUM_S-1:0]           RLAST_S, RVALID_S, RREADY_S;
    logic [ID_BITS-1:0]         RID_M;
    logic [DATA_BITS-1:0]       RDATA_M;
    logic [1:0]                 RRESP_M;
    logic                       RLAST_M;
    logic [NUM_M-1:0]           RVALID_M, RREADY_M;
`ifdef AXI_R_ARB_MUX_DECERR_EN
    logic [15:0]                err_cnt;
`endif

    axi_r_arb_mux #(.NUM_S(NUM_S), .NUM_M(NUM_M), .ID_BITS(ID_BITS), .DATA_BITS(DATA_BITS)) dut (
        .clk(clk), .rst(rst),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
`ifdef AXI_R_ARB_MUX_DECERR_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_M-1:0]     sel;
        logic [ID_BITS-1:0]   id;
        logic [DATA_BITS-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } sbeat_t;

    typedef struct packed {
        logic [NUM_M-1:0]     m;
        logic [ID_BITS-1:0]   id;
        logic [DATA_BITS-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } exp_t;

    typedef struct packed {
        logic [1:0]       s;
        sbeat_t           b;
        logic [NUM_M-1:0] exp_m;
    } vec_t;

    localparam int NV = 6;
    vec_t   vecs [NV];
    sbeat_t sq [NUM_S][$];
    exp_t   exp_q [$];
    int     grant_log [$];

    int checks = 0;
    int errors = 0;
    int cur_lock = -1;
    int tcyc = 0;
    logic [NUM_S-1:0] rs_hist [64];
    logic [NUM_M-1:0] rv_hist [64];
    logic             rl_hist [64];
    logic             prev_pend = 1'b0;
    logic [NUM_M-1:0] prev_v;
    logic [ID_BITS+DATA_BITS+2:0] prev_pl;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic sbeat_t mkb(input logic [NUM_M-1:0] sel, input logic [ID_BITS-1:0] id,
                                   input logic [DATA_BITS-1:0] data, input logic [1:0] resp,
                                   input logic last);
        sbeat_t b;
        b.sel = sel; b.id = id; b.data = data; b.resp = resp; b.last = last;
        return b;
    endfunction

    task automatic push_beat(input int k, input sbeat_t b, input logic [NUM_M-1:0] m);
        exp_t e;
        sq[k].push_back(b);
        e.m = m; e.id = b.id; e.data = b.data; e.resp = b.resp; e.last = b.last;
        exp_q.push_back(e);
    endtask

    task automatic drive_slaves();
        for (int k = 0; k < NUM_S; k++) begin
            sbeat_t b;
            b = '0;
            if (sq[k].size() > 0) b = sq[k][0];
            RVALID_S[k]                      = (sq[k].size() > 0);
            RID_S[k*IDS_BITS +: IDS_BITS]    = {b.sel, b.id};
            RDATA_S[k*DATA_BITS +: DATA_BITS] = b.data;
            RRESP_S[k*2 +: 2]                = b.resp;
            RLAST_S[k]                       = b.last;
        end
    endtask

    task automatic monitor();
        logic [NUM_M-1:0] drn;
        drn = RVALID_M & RREADY_M;
        chk("rvalid_m_onehot0", 64'($onehot0(RVALID_M)), 64'd1);
        if (prev_pend && !rst) begin
            chk("hold_valid", RVALID_M, prev_v);
            chk("hold_payload", {RID_M, RDATA_M, RRESP_M, RLAST_M}, prev_pl);
        end
        if (drn != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", drn, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_master", RVALID_M, e.m);
                chk("beat_id", RID_M, e.id);
                chk("beat_data", RDATA_M, e.data);
                chk("beat_resp", RRESP_M, e.resp);
                chk("beat_last", RLAST_M, e.last);
            end
        end
        prev_pend = (RVALID_M != '0) && (drn == '0);
        prev_v    = RVALID_M;
        prev_pl   = {RID_M, RDATA_M, RRESP_M, RLAST_M};
        if (tcyc < 64) begin
            rs_hist[tcyc] = RREADY_S;
            rv_hist[tcyc] = RVALID_M;
            rl_hist[tcyc] = RLAST_M;
        end
    endtask

    // One clock: present slave heads, sample/compare at negedge, retire accepted slave beats after the edge.
    task automatic step();
        logic [NUM_S-1:0] hs;
        drive_slaves();
        @(negedge clk);
        hs = RVALID_S & RREADY_S;
        monitor();
        @(posedge clk);
        #1;
        tcyc++;
        for (int k = 0; k < NUM_S; k++) begin
            if (hs[k] && sq[k].size() > 0) begin
                sbeat_t b;
                b = sq[k].pop_front();
                if (cur_lock != -1) chk("burst_interleave", k, cur_lock);
                cur_lock = b.last ? -1 : k;
                if (b.last) grant_log.push_back(k);
            end
        end
    endtask

    function automatic int pending();
        int n = exp_q.size();
        for (int k = 0; k < NUM_S; k++) n += sq[k].size();
        if (RVALID_M != '0) n++;
        return n;
    endfunction

    task automatic run_idle(input int max_cyc);
        int n = 0;
        while (pending() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain_complete", pending(), 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        RREADY_M = '0;
        repeat (n) step();
        rst = 1'b0;
        for (int k = 0; k < NUM_S; k++) sq[k].delete();
        exp_q.delete();
        cur_lock = -1;
        prev_pend = 1'b0;
        RREADY_M = '1;
        drive_slaves();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rvalid_m"}, RVALID_M, 0);
        chk({tag, "_rready_s"}, RREADY_S, 0);
        chk({tag, "_rid_m"}, RID_M, 0);
        chk({tag, "_rdata_m"}, RDATA_M, 0);
        chk({tag, "_rlast_m"}, RLAST_M, 0);
        chk({tag, "_rresp_m"}, RRESP_M, 2'b11);
`ifdef AXI_R_ARB_MUX_DECERR_EN
        chk({tag, "_err_cnt"}, err_cnt, 0);
`endif
    endtask

    initial begin
        vecs[0] = '{2'd0, '{2'b01, 4'h3, 32'hA000_0001, 2'b00, 1'b1}, 2'b01};
        vecs[1] = '{2'd1, '{2'b10, 4'hF, 32'h5555_AAAA, 2'b01, 1'b1}, 2'b10};
        vecs[2] = '{2'd2, '{2'b01, 4'h0, 32'hFFFF_FFFF, 2'b10, 1'b1}, 2'b01};
        vecs[3] = '{2'd2, '{2'b10, 4'h9, 32'h0000_0000, 2'b11, 1'b1}, 2'b10};
        vecs[4] = '{2'd0, '{2'b10, 4'h5, 32'h1234_5678, 2'b00, 1'b1}, 2'b10};
        vecs[5] = '{2'd1, '{2'b01, 4'hA, 32'hDEAD_BEEF, 2'b01, 1'b1}, 2'b01};

        RVALID_S = '0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = '0;
        RREADY_M = '1;
        do_reset(2);
        chk_reset_outputs("reset");

        // Single 4-beat burst from slave 1 to M0.
        tcyc = 0;
        for (int i = 0; i < 4; i++)
            push_beat(1, mkb(2'b01, 4'h7, 32'h1000 + i, 2'b00, i == 3), 2'b01);
        run_idle(20);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("burst4_rready_s1[%0d]", c), rs_hist[c][1], c < 4);
            chk($sformatf("burst4_rvalid_m0[%0d]", c), rv_hist[c][0], (c >= 1) && (c <= 4));
            chk($sformatf("burst4_rlast_m[%0d]", c), rl_hist[c], c == 4);
        end

        // Slaves 0 and 2 valid from reset: slave 0's whole burst goes first.
        do_reset(2);
        grant_log.delete();
        tcyc = 0;
        push_beat(0, mkb(2'b10, 4'h1, 32'h0A00, 2'b00, 1'b0), 2'b10);
        push_beat(0, mkb(2'b10, 4'h1, 32'h0A01, 2'b00, 1'b1), 2'b10);
        push_beat(2, mkb(2'b01, 4'h2, 32'h2A00, 2'b00, 1'b0), 2'b01);
        push_beat(2, mkb(2'b01, 4'h2, 32'h2A01, 2'b00, 1'b1), 2'b01);
        run_idle(20);
        chk("lock_grant_cnt", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("lock_first", grant_log[0], 0);
            chk("lock_second", grant_log[1], 2);
        end
        chk("lock_rready_c0", rs_hist[0], 3'b001);
        chk("lock_rready_c1", rs_hist[1], 3'b001);
        chk("lock_rready_c2", rs_hist[2], 3'b100);

        // M1 back-pressure for 3 cycles mid-burst.
        tcyc = 0;
        for (int i = 0; i < 4; i++)
            push_beat(2, mkb(2'b10, 4'hC, 32'hC0DE_0000 + i, 2'b01, i == 3), 2'b10);
        step();
        step();
        RREADY_M[1] = 1'b0;
        repeat (3) step();
        RREADY_M[1] = 1'b1;
        run_idle(20);
        for (int c = 2; c < 5; c++) begin
            chk($sformatf("stall_rready_s2[%0d]", c), rs_hist[c][2], 0);
            chk($sformatf("stall_rvalid_m1[%0d]", c), rv_hist[c][1], 1);
        end

        // Round-robin fairness with 1-beat bursts on every slave.
        do_reset(2);
        grant_log.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_S; k++)
                push_beat(k, mkb((k == 1) ? 2'b10 : 2'b01, 4'(k), 32'hD000 + r*16 + k, 2'b00, 1'b1),
                          (k == 1) ? 2'b10 : 2'b01);
        run_idle(30);
        chk("rr_grant_cnt", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size() && i < 6; i++)
            chk($sformatf("rr_grant[%0d]", i), grant_log[i], i % 3);

        // Table of single-beat transfers across slaves, masters, ids and responses.
        for (int i = 0; i < NV; i++) begin
            push_beat(int'(vecs[i].s), vecs[i].b, vecs[i].exp_m);
            run_idle(10);
        end

        // Invalid master-select field.
        tcyc = 0;
`ifdef AXI_R_ARB_MUX_DECERR_EN
        sq[1].push_back(mkb(2'b00, 4'h4, 32'hBAD0, 2'b00, 1'b1));
        run_idle(10);
        chk("decerr_sunk", rs_hist[0][1], 1);
        chk("decerr_cnt1", err_cnt, 1);
        sq[1].push_back(mkb(2'b11, 4'h4, 32'hBAD1, 2'b00, 1'b1));
        run_idle(10);
        chk("decerr_cnt2", err_cnt, 2);
        begin
            int nv = 0;
            for (int c = 0; c < tcyc && c < 64; c++) nv += (rv_hist[c] != '0);
            chk("decerr_no_rvalid", nv, 0);
        end
`else
        sq[1].push_back(mkb(2'b00, 4'h4, 32'hBAD0, 2'b00, 1'b1));
        repeat (10) step();
        begin
            int nr = 0, nv = 0;
            for (int c = 0; c < 10; c++) begin
                nr += rs_hist[c][1];
                nv += (rv_hist[c] != '0);
            end
            chk("badsel_stall_rready", nr, 0);
            chk("badsel_no_rvalid", nv, 0);
        end
        do_reset(2);
`endif

        // Reset at beat 2 of a 4-beat burst.
        do_reset(2);
        tcyc = 0;
        grant_log.delete();
        for (int i = 0; i < 4; i++)
            push_beat(0, mkb(2'b01, 4'h6, 32'hE000 + i, 2'b10, i == 3), 2'b01);
        step();
        step();
        do_reset(1);
        chk("midrst_rready_during_rst", rs_hist[2], 0);
        chk_reset_outputs("midrst");
        push_beat(2, mkb(2'b10, 4'hB, 32'hF00D, 2'b00, 1'b1), 2'b10);
        run_idle(10);
        chk("midrst_restart_cnt", grant_log.size(), 1);
        if (grant_log.size() == 1) chk("midrst_restart_slave", grant_log[0], 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_r_arb_mux.md
AXI_R_ARB_MUX -- requirements
Module: axi_r_arb_mux

Interface
REQ-001 SHALL have parameter NUM_S, default 3, number of read-data sources (slaves, including the default slave), range 2..8.
REQ-002 SHALL have parameter NUM_M, default 2, number of read-data sinks (masters), range 1..4.
REQ-003 SHALL have parameter ID_BITS, default 4, master-side RID width.
REQ-004 SHALL have parameter DATA_BITS, default 32, RDATA width.
REQ-005 SHALL derive IDS_BITS = ID_BITS + NUM_M; RID_S[IDS_BITS-1:ID_BITS] is a one-hot master-select field.
REQ-006 SHALL have clk input 1: the single clock; one clock, reset synchronous and active-high.
REQ-007 SHALL have rst input 1: synchronous active-high reset.
REQ-008 SHALL have RID_S input NUM_S*IDS_BITS: flattened slave RIDs, slave k at [k*IDS_BITS +: IDS_BITS].
REQ-009 SHALL have RDATA_S input NUM_S*DATA_BITS, RRESP_S input NUM_S*2, RLAST_S input NUM_S and RVALID_S input NUM_S: flattened slave R-channel payload and valid.
REQ-010 SHALL have RREADY_S output NUM_S: per-slave ready.
REQ-011 SHALL have RID_M output ID_BITS, RDATA_M output DATA_BITS, RRESP_M output 2 and RLAST_M output 1: shared master payload from the output register.
REQ-012 SHALL have RVALID_M output NUM_M and RREADY_M input NUM_M: per-master valid and ready.

Function
REQ-013 SHALL arbitrate among slaves with RVALID_S high by round-robin: priority starts at (last granted index + 1) mod NUM_S; after reset, slave 0 has highest priority.
REQ-014 SHALL lock the grant to the winning slave from its first accepted beat until the beat with RLAST=1 is accepted; no other slave is granted while locked.
REQ-015 SHALL update the round-robin pointer only on acceptance of an RLAST beat.
REQ-016 SHALL buffer each beat in a 1-entry output register: entry states EMPTY/FULL; latency is 1 cycle from slave handshake to RVALID_M.
REQ-017 SHALL assert RREADY_S[k] only when k is granted, RVALID_S[k]=1, the select field is valid, and the register is EMPTY or being drained in the same cycle.
REQ-018 SHALL sustain 1 beat/cycle: capture and drain in the same cycle keep the entry FULL with the new beat.
REQ-019 SHALL assert exactly the RVALID_M[j] whose select bit was set in the captured beat, and only while FULL.
REQ-020 SHALL drain the entry when RVALID_M[j] and RREADY_M[j] are both high, returning to EMPTY unless a new beat is captured that cycle.
REQ-021 SHALL drive RID_M from the stored RID[ID_BITS-1:0].
REQ-022 SHALL hold payload stable while RVALID_M[j]=1 and RREADY_M[j]=0.
REQ-023 SHALL treat a select field that is zero or has more than one bit set as invalid.
REQ-024 SHALL never drop, duplicate or reorder beats of a burst.

Reset
REQ-025 SHALL, on rst=1 at a clk edge: entry EMPTY, lock cleared, RR pointer = NUM_S-1, all RVALID_M=0, all RREADY_S=0, RID_M/RDATA_M/RLAST_M=0, RRESP_M=2'b11 (DECERR), error counter 0.
REQ-026 SHALL, on reset mid-burst, abandon the burst and the buffered beat, and restart arbitration at the next cycle.

Configuration
REQ-027 SHALL support macro AXI_R_ARB_MUX_DECERR_EN.
REQ-028 SHALL, when AXI_R_ARB_MUX_DECERR_EN is defined: sink beats with an invalid select field (RREADY_S=1, no RVALID_M); lock/RLAST/pointer rules still apply; a 16-bit saturating output err_cnt counts sunk beats.
REQ-029 SHALL, when the macro is not defined: stall a granted slave with an invalid select field indefinitely (RREADY_S=0), and have no err_cnt port.

Verification
REQ-030 SHALL cover: slave 1 sends a 4-beat burst with select=2'b01, M0 ready always -> beats on RVALID_M[0] at cycles 2..5, RLAST_M on the 4th, RREADY_S[1] high for 4 cycles.
REQ-031 SHALL cover: slaves 0 and 2 both valid from reset with 2-beat bursts -> slave 0 served first, then slave 2; slave 2 is not granted before slave 0's RLAST is accepted.
REQ-032 SHALL cover: M1 RREADY low for 3 cycles mid-burst -> payload held, RREADY_S low, no beat lost; all 4 data values arrive in order.
REQ-033 SHALL cover: RR fairness, all three slaves continuously issuing 1-beat bursts -> grant order 0,1,2,0,1,2.
REQ-034 SHALL cover: select=2'b00 beat with the macro defined -> beat sunk, err_cnt=1, no RVALID_M; without the macro -> RREADY_S stays 0 for 10 cycles.
REQ-035 SHALL cover: rst asserted at beat 2 of a 4-beat burst -> next cycle all outputs at reset values and RVALID_M=0.
